fifo_reader: RTL and testbench



---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_reader_skid.sv | 55 +++++
 rtl/fifo_reader.sv | 80 ++++++++
 tb/tb_fifo_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants for the FIFO read-side drain engine
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int OUT_DEPTH      = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/fifo_reader_skid.sv
// rtl/fifo_reader_skid.sv - 2-entry output buffer; head is always presented on rd_data
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  xfer;

  assign rd_valid = (occ != 2'd0);
  assign rd_data  = head_q;
  assign xfer     = rd_valid & rd_ready;

  // The pop rule upstream guarantees a write never lands on a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({wr_en, xfer})
        2'b10: begin
          if (occ == 2'd0) head_q <= wr_data;
          else             tail_q <= wr_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= wr_data;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO drain engine presenting words as a valid/ready stream
// FIFO_READER_COUNT_EN adds the word_count port counting delivered words.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
`ifdef FIFO_READER_COUNT_EN
  ,
  parameter int COUNT_WIDTH = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  output logic                   fifo_pop,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] word_count
`endif
);

  localparam logic [2:0] DEPTH = 3'(OUT_DEPTH);

  logic [1:0] state;
  logic       inflight;
  logic [1:0] occ;
  logic       xfer;
  logic [2:0] pending;

  assign xfer    = m_valid & m_ready;
  // Words held or arriving after this cycle's transfer; must leave room for one more.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
  assign fifo_pop = !rst && (state == ST_RUN) && !fifo_empty && (pending < DEPTH);
  assign busy     = (state != ST_IDLE);

  fifo_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (inflight),
    .wr_data  (fifo_rdata),
    .rd_ready (m_ready),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .occ      (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_pop;
      case (state)
        ST_IDLE:  if (enable) state <= ST_RUN;
        ST_RUN:   if (!enable) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable)                          state <= ST_RUN;
          else if (!inflight && occ == 2'd0)   state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_READER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)       word_count <= '0;
    else if (xfer) word_count <= word_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - randomized scoreboard bench for fifo_reader
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_pop;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       busy;
`ifdef FIFO_READER_COUNT_EN
  logic [15:0] word_count;
`endif

  always #5 clk = ~clk;

  fifo_reader #(
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
`ifdef FIFO_READER_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_d[$];
  int         exp_t[$];
  int         n = 0;
  int         delivered = 0;
  int         pops = 0;
  bit [15:0]  cnt_model = 16'd0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         obs_pop, obs_valid, obs_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Registered-read FIFO model: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_pop && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
  end

  task automatic step(input bit r, input bit e, input bit rd, input bit fe);
    bit exp_valid;
    bit xfer;
    @(negedge clk);
    rst        = r;
    enable     = e;
    m_ready    = rd;
    fifo_empty = (fifo_q.size() == 0) || fe;
    #1;
    obs_pop   = fifo_pop;
    obs_valid = m_valid;
    obs_busy  = busy;
    if (r) begin
      check("pop_in_reset", fifo_pop, 0);
      exp_d.delete();
      exp_t.delete();
      prev_hold = 1'b0;
      cnt_model = 16'd0;
    end else begin
      check("pop_while_empty", fifo_pop && fifo_empty, 0);
      exp_valid = (exp_d.size() > 0) && (exp_t[0] <= n);
      check("m_valid", m_valid, exp_valid);
      if (prev_hold) check("m_data_hold", m_data, prev_data);
      if (m_valid && exp_d.size() > 0) check("m_data_order", m_data, exp_d[0]);
`ifdef FIFO_READER_COUNT_EN
      check("word_count", word_count, cnt_model);
`endif
      xfer = m_valid && m_ready;
      if (xfer && exp_d.size() > 0) begin
        void'(exp_d.pop_front());
        void'(exp_t.pop_front());
        delivered++;
        cnt_model++;
      end
      if (fifo_pop) begin
        exp_d.push_back(fifo_q.size() > 0 ? fifo_q[0] : 8'h00);
        exp_t.push_back(n + 2);
        pops++;
      end
      check("outstanding_le_2", exp_d.size() <= 2, 1);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
    n++;
  endtask

  task automatic do_reset();
    fifo_q.delete();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    do begin
      step(0, 0, 1, 0);
      i++;
    end while (obs_busy && i < bound);
    check("drain_busy_falls", obs_busy, 0);
  endtask

  initial begin
    int first_pop, first_valid, last_pop, pop_cyc, val_cyc, busy_low, d0, p0, i;

    // Reset state
    do_reset();
    step(0, 0, 0, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_pop", fifo_pop, 0);
`ifdef FIFO_READER_COUNT_EN
    check("rst_word_count", word_count, 0);
`endif

    // Full-rate drain of three words
    fifo_q = '{8'h11, 8'h22, 8'h33};
    first_pop = -1; first_valid = -1; last_pop = -1;
    pop_cyc = 0; val_cyc = 0; busy_low = 0; d0 = delivered;
    for (int c = 0; c < 10; c++) begin
      step(0, 1, 1, 0);
      if (obs_pop) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pop_cyc++;
      end
      if (obs_valid) begin
        if (first_valid < 0) first_valid = c;
        val_cyc++;
      end
      if (c > 0 && !obs_busy) busy_low++;
    end
    check("t1_pop_cycles", pop_cyc, 3);
    check("t1_pop_consecutive", last_pop - first_pop, 2);
    check("t1_first_latency", first_valid - first_pop, 2);
    check("t1_valid_cycles", val_cyc, 3);
    check("t1_busy_held", busy_low, 0);
    check("t1_delivered", delivered - d0, 3);
    drain(10);

    // Back-pressure fills the buffer, then releases in order
    do_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33};
    p0 = pops; d0 = delivered;
    for (int c = 0; c < 6; c++) step(0, 1, 0, 0);
    check("t2_pops_stalled", pops - p0, 2);
    check("t2_valid_held", obs_valid, 1);
    check("t2_head_held", m_data, 8'h11);
    for (int c = 0; c < 6; c++) step(0, 1, 1, 0);
    check("t2_delivered", delivered - d0, 3);
    drain(10);

    // enable drops on a pop cycle
    do_reset();
    fifo_q = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6};
    p0 = pops; d0 = delivered; i = 0;
    do begin
      step(0, 1, 1, 0);
      i++;
    end while (!obs_pop && i < 10);
    check("t3_first_pop_seen", obs_pop, 1);
    step(0, 0, 1, 0);
    check("t3_drop_cycle_pop", obs_pop, 1);
    pop_cyc = 0;
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 1, 0);
      if (obs_pop) pop_cyc++;
    end
    check("t3_no_pops_after", pop_cyc, 0);
    check("t3_inflight_delivered", delivered - d0, pops - p0);
    check("t3_idle", obs_busy, 0);

    // fifo_empty toggling every cycle
    do_reset();
    for (int k = 0; k < 12; k++) fifo_q.push_back(8'($urandom));
    d0 = delivered;
    for (int c = 0; c < 40; c++) step(0, 1, 1'($urandom_range(0, 1)), 1'(c % 2));
    i = 0;
    while (delivered - d0 < 12 && i < 40) begin
      step(0, 1, 1, 0);
      i++;
    end
    check("t4_delivered", delivered - d0, 12);
    drain(10);

    // Reset with a full buffer, then reset with a word in flight
    do_reset();
    for (int k = 0; k < 6; k++) fifo_q.push_back(8'(8'h50 + k));
    for (int c = 0; c < 5; c++) step(0, 1, 0, 0);
    check("t5_full_before_rst", exp_d.size(), 2);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check("t5_valid_after_rst", obs_valid, 0);
    check("t5_busy_after_rst", obs_busy, 0);
`ifdef FIFO_READER_COUNT_EN
    check("t5_count_after_rst", word_count, 0);
`endif
    fifo_q.push_back(8'h77);
    i = 0;
    do begin
      step(0, 1, 1, 0);
      i++;
    end while (!obs_pop && i < 10);
    check("t5_pop_before_rst", obs_pop, 1);
    step(1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 1, 0);
      check("t5_stale_not_captured", obs_valid, 0);
    end

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) fifo_q.push_back(8'($urandom));
      step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
    end
    i = 0;
    while ((fifo_q.size() > 0 || exp_d.size() > 0) && i < 100) begin
      step(0, 1, 1, 0);
      i++;
    end
    check("rand_flushed", fifo_q.size() + exp_d.size(), 0);
    drain(10);

`ifdef FIFO_READER_COUNT_EN
    // Counter wrap
    do_reset();
    d0 = delivered; i = 0;
    while (delivered - d0 < 65537 && i < 70000) begin
      if (fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
      step(0, 1, 1, 0);
      i++;
    end
    check("wrap_transfers", delivered - d0, 65537);
    step(0, 0, 0, 0);
    check("wrap_word_count", word_count, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
